// File: rtl/ttl_164_load_sequencer.sv
// Shares one 74164-style SIPO register between two load requesters and shifts each word in MSB-first.
// Define SEQ_ROUND_ROBIN_EN to arbitrate ties round-robin; the default is fixed priority to req0.
module ttl_164_load_sequencer #(
    parameter int NBITS = 8
) (
    input  logic             clk,
    input  logic             Reset_n,
    input  logic             Cen,
    input  logic             req0,
    input  logic [NBITS-1:0] data0,
    input  logic             req1,
    input  logic [NBITS-1:0] data1,
    output logic             ack0,
    output logic             ack1,
    output logic             ser_data,
    output logic             sh_cen,
    output logic             mr_n,
    output logic             busy,
    output logic             grant,
    output logic             done
);

    localparam int CW = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(NBITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        WAIT,
        PULSE,
        DONE
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    bitCnt_q;
    logic [NBITS-1:0] hold_q;
    logic             ack0_q;
    logic             ack1_q;
    logic             serData_q;
    logic             shCen_q;
    logic             mrN_q;
    logic             busy_q;
    logic             grant_q;
    logic             done_q;
    logic             pick1_d;

`ifdef SEQ_ROUND_ROBIN_EN
    // rrPtr_q names the requester that wins the next tie
    logic rrPtr_q;

    assign pick1_d = req1 & (~req0 | rrPtr_q);

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rrPtr_q <= 1'b0;
        end else if (state_q == IDLE && (req0 || req1)) begin
            rrPtr_q <= ~pick1_d;
        end
    end
`else
    assign pick1_d = req1 & ~req0;
`endif

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= IDLE;
            bitCnt_q  <= '0;
            hold_q    <= '0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            serData_q <= 1'b0;
            shCen_q   <= 1'b0;
            mrN_q     <= 1'b1;
            busy_q    <= 1'b0;
            grant_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            shCen_q <= 1'b0;
            done_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (req0 || req1) begin
                        hold_q  <= pick1_d ? data1 : data0;
                        ack0_q  <= ~pick1_d;
                        ack1_q  <= pick1_d;
                        grant_q <= pick1_d;
                        busy_q  <= 1'b1;
                        mrN_q   <= 1'b0;
                        state_q <= CLEAR;
                    end
                end
                CLEAR: begin
                    mrN_q    <= 1'b1;
                    bitCnt_q <= LAST_IDX;
                    state_q  <= WAIT;
                end
                WAIT: begin
                    if (Cen) begin
                        serData_q <= hold_q[bitCnt_q];
                        shCen_q   <= 1'b1;
                        state_q   <= PULSE;
                    end
                end
                // A Cen arriving here is dropped so sh_cen always has a low cycle between pulses
                PULSE: begin
                    if (bitCnt_q == '0) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        bitCnt_q <= bitCnt_q - CW'(1);
                        state_q  <= WAIT;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ack0     = ack0_q;
    assign ack1     = ack1_q;
    assign ser_data = serData_q;
    assign sh_cen   = shCen_q;
    assign mr_n     = mrN_q;
    assign busy     = busy_q;
    assign grant    = grant_q;
    assign done     = done_q;

endmodule
